// File: rtl/spi_master.sv
// SPI mode-0 master: start/busy/done host handshake, registered spi_clk/cs_n/mosi,
// miso captured on spi_clk rising edges. Frame = SETUP, DATA_WIDTH clock periods, HOLD.
module spi_master #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4,
  parameter int LSB_FIRST  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  busy,
  output logic                  done,
  output logic                  spi_clk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  cs_n
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int BIT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] BIT_ALL  = BIT_W'(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_e;

  state_e                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  spi_clk_q, spi_clk_d;
  logic                  mosi_q, mosi_d;
  logic                  cs_n_q, cs_n_d;
  logic [DATA_WIDTH-1:0] tx_nxt;

  function automatic logic lead_bit(input logic [DATA_WIDTH-1:0] w);
    return (LSB_FIRST != 0) ? w[0] : w[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] tx_adv(input logic [DATA_WIDTH-1:0] w);
    return (LSB_FIRST != 0) ? (w >> 1) : (w << 1);
  endfunction

  // Receive register fills in the same order bits leave the transmit register.
  function automatic logic [DATA_WIDTH-1:0] rx_ins(input logic [DATA_WIDTH-1:0] r, input logic b);
    return (LSB_FIRST != 0) ? {b, r[DATA_WIDTH-1:1]} : {r[DATA_WIDTH-2:0], b};
  endfunction

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    spi_clk_d = spi_clk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    tx_nxt    = tx_adv(tx_sh_q);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          tx_sh_d = tx_data;
          mosi_d  = lead_bit(tx_data);
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          div_d   = '0;
          bit_d   = '0;
        end
      end
      SETUP: begin
        if (div_q == DIV_LAST) begin
          state_d   = XFER;
          div_d     = '0;
          spi_clk_d = 1'b1;
          rx_sh_d   = rx_ins(rx_sh_q, miso);
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      XFER: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + DIV_W'(1);
        end else begin
          div_d = '0;
          if (spi_clk_q) begin
            spi_clk_d = 1'b0;
            bit_d     = bit_q + BIT_W'(1);
            if (bit_q != BIT_LAST) begin
              tx_sh_d = tx_nxt;
              mosi_d  = lead_bit(tx_nxt);
            end
          end else if (bit_q == BIT_ALL) begin
            // last low half-period has elapsed; cs_n stays low through HOLD
            state_d = HOLD;
          end else begin
            spi_clk_d = 1'b1;
            rx_sh_d   = rx_ins(rx_sh_q, miso);
          end
        end
      end
      HOLD: begin
        if (div_q == DIV_LAST) begin
          state_d   = IDLE;
          div_d     = '0;
          bit_d     = '0;
          cs_n_d    = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          mosi_d    = 1'b0;
          rx_data_d = rx_sh_q;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      spi_clk_q <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      spi_clk_q <= spi_clk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
    end
  end

  assign rx_data = rx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign spi_clk = spi_clk_q;
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: three instances (CLK_DIV=4 LSB-first, CLK_DIV=1, MSB-first)
// driven by a behavioural mode-0 slave and checked against frame-level expectations.
module tb_spi_master;

  logic       clk = 1'b0;
  logic [2:0] reset_w = 3'b000, start_w = 3'b000;
  logic [2:0] busy_w, done_w, sclk_w, mosi_w, miso_w, cs_w;
  logic [2:0] lbk = 3'b000, miso_drv = 3'b000;
  logic [7:0] tx_w [3];
  logic [7:0] rx_w [3];

  int n_cmp = 0, n_bad = 0;

  // slave / bus monitor state, per instance
  logic [7:0]  slave_word [3];
  logic [31:0] mosi_cap [3];
  int          idx [3], rises [3], hi [3], cs_low [3], done_cnt [3];
  bit          prev_sclk [3];

  assign miso_w = (lbk & mosi_w) | (~lbk & miso_drv);

  always #5 clk = ~clk;

  spi_master #(.DATA_WIDTH(8), .CLK_DIV(4), .LSB_FIRST(1)) u_dut (
    .clk(clk), .reset(reset_w[0]), .start(start_w[0]), .tx_data(tx_w[0]), .rx_data(rx_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .spi_clk(sclk_w[0]), .mosi(mosi_w[0]),
    .miso(miso_w[0]), .cs_n(cs_w[0]));

  spi_master #(.DATA_WIDTH(8), .CLK_DIV(1), .LSB_FIRST(1)) u_fast (
    .clk(clk), .reset(reset_w[1]), .start(start_w[1]), .tx_data(tx_w[1]), .rx_data(rx_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .spi_clk(sclk_w[1]), .mosi(mosi_w[1]),
    .miso(miso_w[1]), .cs_n(cs_w[1]));

  spi_master #(.DATA_WIDTH(8), .CLK_DIV(4), .LSB_FIRST(0)) u_msb (
    .clk(clk), .reset(reset_w[2]), .start(start_w[2]), .tx_data(tx_w[2]), .rx_data(rx_w[2]),
    .busy(busy_w[2]), .done(done_w[2]), .spi_clk(sclk_w[2]), .mosi(mosi_w[2]),
    .miso(miso_w[2]), .cs_n(cs_w[2]));

  function automatic bit lsb_of(input int i);
    return i != 2;
  endfunction

  function automatic int div_of(input int i);
    return (i == 1) ? 1 : 4;
  endfunction

  // cs_n falls, SETUP + 8 clock periods + HOLD, then the done cycle
  function automatic int exp_lat(input int i);
    return (2 * 8 + 2) * div_of(i) + 1;
  endfunction

  // word reconstructed from the bits seen on mosi at rising edges
  function automatic logic [7:0] cap_word(input int i);
    logic [7:0] w = '0;
    for (int k = 0; k < 8; k++) w[lsb_of(i) ? k : 7 - k] = mosi_cap[i][k];
    return w;
  endfunction

  // Mode-0 slave: next bit appears after each falling edge, first bit while cs_n is high.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int b;
      if (cs_w[i] === 1'b1) idx[i] = 0;
      else begin
        if (prev_sclk[i] && sclk_w[i] === 1'b0) idx[i]++;
        if (!prev_sclk[i] && sclk_w[i] === 1'b1) begin
          if (rises[i] < 32) mosi_cap[i][rises[i]] = mosi_w[i];
          rises[i]++;
        end
        if (sclk_w[i] === 1'b1) hi[i]++;
        cs_low[i]++;
      end
      if (done_w[i] === 1'b1) done_cnt[i]++;
      prev_sclk[i] = (sclk_w[i] === 1'b1);
      b = lsb_of(i) ? idx[i] : 7 - idx[i];
      miso_drv[i] = (idx[i] < 8) ? slave_word[i][b] : 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr(input int i);
    rises[i] = 0; hi[i] = 0; cs_low[i] = 0; done_cnt[i] = 0; mosi_cap[i] = '0;
  endtask

  // One frame on instance i; lat = cycles from start cycle to done (-1 on timeout).
  task automatic run(input int i, input logic [7:0] tx, input logic [7:0] sw, input bit lb,
                     input int glitch_at, output int lat, output logic [2:0] first);
    int n;
    slave_word[i] = sw; lbk[i] = lb; clr(i);
    tx_w[i] = tx; start_w[i] = 1'b1;
    tick();
    start_w[i] = 1'b0;
    first = {busy_w[i], cs_w[i], mosi_w[i]};
    n = 1;
    while (done_w[i] !== 1'b1 && n < 400) begin
      start_w[i] = (n == glitch_at);
      if (n == glitch_at) tx_w[i] = 8'h55;
      tick();
      n++;
    end
    start_w[i] = 1'b0;
    lat = (done_w[i] === 1'b1) ? n : -1;
    tick();
  endtask

  task automatic test_reset();
    reset_w = 3'b000;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if ({cs_w[i], sclk_w[i], mosi_w[i], busy_w[i], done_w[i]} !== 5'b10000) begin
        n_bad++; $display("FAIL reset_ctl[%0d] got %b want 10000", i, {cs_w[i], sclk_w[i], mosi_w[i], busy_w[i], done_w[i]}); end
      n_cmp++; if (rx_w[i] !== 8'h00) begin n_bad++; $display("FAIL reset_rx[%0d] got %h want 00", i, rx_w[i]); end
    end
    reset_w = 3'b111;
    repeat (2) tick();
    n_cmp++; if (cs_w !== 3'b111 || busy_w !== 3'b000) begin
      n_bad++; $display("FAIL post_reset_idle got cs=%b busy=%b want 111/000", cs_w, busy_w); end
  endtask

  task automatic test_basic();
    int lat; logic [2:0] first;
    run(0, 8'hA5, 8'h3C, 1'b0, -1, lat, first);
    n_cmp++; if (first !== 3'b101) begin n_bad++; $display("FAIL basic_first got %b want 101", first); end
    n_cmp++; if (lat !== exp_lat(0)) begin n_bad++; $display("FAIL basic_lat got %0d want %0d", lat, exp_lat(0)); end
    n_cmp++; if (rx_w[0] !== 8'h3C) begin n_bad++; $display("FAIL basic_rx got %h want 3c", rx_w[0]); end
    n_cmp++; if (mosi_cap[0][7:0] !== 8'b1010_0101) begin n_bad++; $display("FAIL basic_mosi got %b want 10100101", mosi_cap[0][7:0]); end
    n_cmp++; if (rises[0] !== 8) begin n_bad++; $display("FAIL basic_rises got %0d want 8", rises[0]); end
    n_cmp++; if (cs_low[0] !== 72) begin n_bad++; $display("FAIL basic_cs_low got %0d want 72", cs_low[0]); end
    n_cmp++; if (hi[0] !== 32) begin n_bad++; $display("FAIL basic_hi got %0d want 32", hi[0]); end
    n_cmp++; if (done_cnt[0] !== 1) begin n_bad++; $display("FAIL basic_done_cnt got %0d want 1", done_cnt[0]); end
  endtask

  task automatic test_loopback();
    int lat; logic [2:0] first;
    logic [7:0] pats [3] = '{8'h81, 8'h00, 8'hFF};
    foreach (pats[k]) begin
      run(0, pats[k], 8'h00, 1'b1, -1, lat, first);
      n_cmp++; if (rx_w[0] !== pats[k]) begin n_bad++; $display("FAIL loopback_rx got %h want %h", rx_w[0], pats[k]); end
    end
    lbk = 3'b000;
  endtask

  task automatic test_random();
    int lat; logic [2:0] first; logic [7:0] tx, sw;
    for (int k = 0; k < 8; k++) begin
      int i = (k < 5) ? 0 : 2;
      tx = 8'($urandom); sw = 8'($urandom);
      run(i, tx, sw, 1'b0, -1, lat, first);
      n_cmp++; if (rx_w[i] !== sw) begin n_bad++; $display("FAIL rand_rx[%0d] got %h want %h", i, rx_w[i], sw); end
      n_cmp++; if (cap_word(i) !== tx) begin n_bad++; $display("FAIL rand_mosi[%0d] got %h want %h", i, cap_word(i), tx); end
      n_cmp++; if (lat !== exp_lat(i)) begin n_bad++; $display("FAIL rand_lat[%0d] got %0d want %0d", i, lat, exp_lat(i)); end
    end
  endtask

  task automatic test_back_to_back();
    int n; logic [7:0] sw1, sw2;
    sw1 = 8'($urandom); sw2 = 8'($urandom);
    slave_word[0] = sw1; clr(0);
    tx_w[0] = 8'h12; start_w[0] = 1'b1;
    tick(); n = 1;
    while (done_w[0] !== 1'b1 && n < 400) begin tick(); n++; end
    n_cmp++; if (n !== 73) begin n_bad++; $display("FAIL b2b_lat1 got %0d want 73", n); end
    n_cmp++; if ({cs_w[0], busy_w[0]} !== 2'b10) begin n_bad++; $display("FAIL b2b_done_cycle got cs/busy %b want 10", {cs_w[0], busy_w[0]}); end
    n_cmp++; if (rx_w[0] !== sw1) begin n_bad++; $display("FAIL b2b_rx1 got %h want %h", rx_w[0], sw1); end
    n_cmp++; if (cap_word(0) !== 8'h12) begin n_bad++; $display("FAIL b2b_mosi1 got %h want 12", cap_word(0)); end
    slave_word[0] = sw2; clr(0); tx_w[0] = 8'h34;
    tick(); n = 1;
    start_w[0] = 1'b0;
    n_cmp++; if (cs_w[0] !== 1'b0) begin n_bad++; $display("FAIL b2b_cs_gap got %b want 0", cs_w[0]); end
    while (done_w[0] !== 1'b1 && n < 400) begin tick(); n++; end
    n_cmp++; if (n !== 73) begin n_bad++; $display("FAIL b2b_lat2 got %0d want 73", n); end
    tick();
    n_cmp++; if (rx_w[0] !== sw2) begin n_bad++; $display("FAIL b2b_rx2 got %h want %h", rx_w[0], sw2); end
    n_cmp++; if (cap_word(0) !== 8'h34) begin n_bad++; $display("FAIL b2b_mosi2 got %h want 34", cap_word(0)); end
  endtask

  task automatic test_busy_ignore();
    int lat; logic [2:0] first;
    run(0, 8'hA5, 8'h66, 1'b0, 10, lat, first);
    repeat (100) tick();
    n_cmp++; if (lat !== 73) begin n_bad++; $display("FAIL busy_lat got %0d want 73", lat); end
    n_cmp++; if (done_cnt[0] !== 1) begin n_bad++; $display("FAIL busy_done_cnt got %0d want 1", done_cnt[0]); end
    n_cmp++; if (cap_word(0) !== 8'hA5) begin n_bad++; $display("FAIL busy_mosi got %h want a5", cap_word(0)); end
    n_cmp++; if (rises[0] !== 8) begin n_bad++; $display("FAIL busy_rises got %0d want 8", rises[0]); end
  endtask

  task automatic test_abort();
    int lat, n; logic [2:0] first;
    run(0, 8'($urandom), 8'h00, 1'b0, -1, lat, first);
    n_cmp++; if (rx_w[0] !== 8'h00) begin n_bad++; $display("FAIL abort_pre_rx got %h want 00", rx_w[0]); end
    slave_word[0] = 8'hFF; clr(0);
    tx_w[0] = 8'hC7; start_w[0] = 1'b1;
    tick(); start_w[0] = 1'b0; n = 0;
    while (rises[0] < 3 && n < 400) begin tick(); n++; end
    n_cmp++; if (rises[0] !== 3) begin n_bad++; $display("FAIL abort_reach got %0d rises want 3", rises[0]); end
    reset_w[0] = 1'b0;
    tick();
    n_cmp++; if ({cs_w[0], sclk_w[0], busy_w[0], done_w[0]} !== 4'b1000) begin
      n_bad++; $display("FAIL abort_state got %b want 1000", {cs_w[0], sclk_w[0], busy_w[0], done_w[0]}); end
    n_cmp++; if (rx_w[0] !== 8'h00) begin n_bad++; $display("FAIL abort_rx got %h want 00", rx_w[0]); end
    repeat (3) tick();
    reset_w[0] = 1'b1;
    repeat (80) tick();
    n_cmp++; if (done_cnt[0] !== 0) begin n_bad++; $display("FAIL abort_no_done got %0d want 0", done_cnt[0]); end
    run(0, 8'h5A, 8'hE1, 1'b0, -1, lat, first);
    n_cmp++; if (lat !== 73 || rx_w[0] !== 8'hE1) begin
      n_bad++; $display("FAIL abort_recover got lat %0d rx %h want 73 e1", lat, rx_w[0]); end
  endtask

  task automatic test_corners();
    int lat; logic [2:0] first; logic [7:0] sw;
    sw = 8'($urandom);
    run(1, 8'hC3, sw, 1'b0, -1, lat, first);
    n_cmp++; if (lat !== 19) begin n_bad++; $display("FAIL fast_lat got %0d want 19", lat); end
    n_cmp++; if (hi[1] !== 8 || rises[1] !== 8) begin n_bad++; $display("FAIL fast_toggle got hi %0d rises %0d want 8 8", hi[1], rises[1]); end
    n_cmp++; if (cs_low[1] !== 18) begin n_bad++; $display("FAIL fast_cs_low got %0d want 18", cs_low[1]); end
    n_cmp++; if (rx_w[1] !== sw) begin n_bad++; $display("FAIL fast_rx got %h want %h", rx_w[1], sw); end
    n_cmp++; if (cap_word(1) !== 8'hC3) begin n_bad++; $display("FAIL fast_mosi got %h want c3", cap_word(1)); end
    sw = 8'($urandom);
    run(2, 8'h80, sw, 1'b0, -1, lat, first);
    n_cmp++; if (first !== 3'b101) begin n_bad++; $display("FAIL msb_first got %b want 101", first); end
    n_cmp++; if (mosi_cap[2][7:0] !== 8'b0000_0001) begin n_bad++; $display("FAIL msb_mosi got %b want 00000001", mosi_cap[2][7:0]); end
    n_cmp++; if (rx_w[2] !== sw) begin n_bad++; $display("FAIL msb_rx got %h want %h", rx_w[2], sw); end
    n_cmp++; if (lat !== 73) begin n_bad++; $display("FAIL msb_lat got %0d want 73", lat); end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      tx_w[i] = '0; slave_word[i] = '0; clr(i); idx[i] = 0; prev_sclk[i] = 1'b0;
    end
    test_reset();
    test_basic();
    test_loopback();
    test_random();
    test_back_to_back();
    test_busy_ignore();
    test_abort();
    test_corners();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
